// File: rtl/elevator_car_ctrl.sv
// Per-car motion and door sequencer: collects stop requests into a pending mask
// and walks the car through them with a collective (SCAN) up/down policy.
module elevator_car_ctrl #(
    parameter int NUM_FLOORS       = 7,
    parameter int DOOR_OPEN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [2:0]            i_req_floor,
    input  logic [NUM_FLOORS-1:0] i_car_call,
    input  logic [2:0]            i_cur_floor,
    input  logic                  i_in_position,
    input  logic                  i_door_hold,
    output logic [1:0]            o_car_state,
    output logic                  o_door_open,
    output logic [NUM_FLOORS-1:0] o_pending_stops,
    output logic                  o_served_valid,
    output logic [2:0]            o_served_floor,
    output logic                  o_req_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    localparam int CW = (DOOR_OPEN_CYCLES > 1) ? $clog2(DOOR_OPEN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_OPEN_CYCLES - 1);

    state_t                r_state;
    logic                  r_dir_up;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [CW-1:0]         r_door_cnt;
    logic                  r_served_valid;
    logic [2:0]            r_served_floor;
    logic                  r_req_err;

    state_t                w_state_next;
    logic                  w_dir_next;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic [CW-1:0]         w_cnt_next;
    logic [NUM_FLOORS-1:0] w_cur_hot;
    logic [NUM_FLOORS-1:0] w_req_hot;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic                  w_req_bad;
    logic                  w_above;
    logic                  w_below;
    logic                  w_here;
    logic                  w_restart;
    logic                  w_enter_door;

    // Floor-relative views of the pending mask; one-hot masks avoid out-of-range indexing.
    always_comb begin
        w_cur_hot = '0;
        w_req_hot = '0;
        w_req_bad = 1'b0;
        w_above   = 1'b0;
        w_below   = 1'b0;
        if (int'(i_cur_floor) < NUM_FLOORS)
            w_cur_hot[i_cur_floor] = 1'b1;
        if (i_req_valid) begin
            if (int'(i_req_floor) < NUM_FLOORS)
                w_req_hot[i_req_floor] = 1'b1;
            else
                w_req_bad = 1'b1;
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && (i > int'(i_cur_floor)))
                w_above = 1'b1;
            if (r_pending[i] && (i < int'(i_cur_floor)))
                w_below = 1'b1;
        end
        w_here    = i_in_position && (|(r_pending & w_cur_hot));
        w_restart = (r_state == S_DOOR_OPEN) && i_in_position &&
                    (|((w_req_hot | i_car_call) & w_cur_hot));
    end

    // Next-state: nothing moves unless the car is aligned at a floor.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir_up;
        if (i_in_position) begin
            case (r_state)
                S_IDLE: begin
                    if (w_here) begin
                        w_state_next = S_DOOR_OPEN;
                    end else if (w_above && (r_dir_up || !w_below)) begin
                        w_state_next = S_MOVE_UP;
                        w_dir_next   = 1'b1;
                    end else if (w_below) begin
                        w_state_next = S_MOVE_DOWN;
                        w_dir_next   = 1'b0;
                    end
                end
                S_MOVE_UP: begin
                    if (w_here)
                        w_state_next = S_DOOR_OPEN;
                    else if (int'(i_cur_floor) >= NUM_FLOORS - 1)
                        w_state_next = S_IDLE;
                end
                S_MOVE_DOWN: begin
                    if (w_here)
                        w_state_next = S_DOOR_OPEN;
                    else if (i_cur_floor == 3'd0)
                        w_state_next = S_IDLE;
                end
                S_DOOR_OPEN: begin
                    if ((r_door_cnt == '0) && !i_door_hold && !w_restart) begin
                        if (r_dir_up && w_above) begin
                            w_state_next = S_MOVE_UP;
                        end else if (!r_dir_up && w_below) begin
                            w_state_next = S_MOVE_DOWN;
                        end else if (w_above) begin
                            w_state_next = S_MOVE_UP;
                            w_dir_next   = 1'b1;
                        end else if (w_below) begin
                            w_state_next = S_MOVE_DOWN;
                            w_dir_next   = 1'b0;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Pending mask and dwell counter; a clear on the door-entry edge beats a same-floor set.
    always_comb begin
        w_enter_door = (w_state_next == S_DOOR_OPEN) && (r_state != S_DOOR_OPEN);
        w_set        = w_req_hot | i_car_call;
        w_clr        = '0;
        if ((r_state == S_DOOR_OPEN) && i_in_position)
            w_set = w_set & ~w_cur_hot;
        if (w_enter_door)
            w_clr = w_cur_hot;
        w_pending_next = (r_pending | w_set) & ~w_clr;

        w_cnt_next = '0;
        if (w_enter_door)
            w_cnt_next = CNT_LOAD;
        else if ((r_state == S_DOOR_OPEN) && (i_door_hold || w_restart))
            w_cnt_next = CNT_LOAD;
        else if ((r_state == S_DOOR_OPEN) && (r_door_cnt != '0))
            w_cnt_next = r_door_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_dir_up       <= 1'b1;
            r_pending      <= '0;
            r_door_cnt     <= '0;
            r_served_valid <= 1'b0;
            r_served_floor <= 3'd0;
            r_req_err      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_dir_up       <= w_dir_next;
            r_pending      <= w_pending_next;
            r_door_cnt     <= w_cnt_next;
            r_served_valid <= w_enter_door;
            if (w_enter_door)
                r_served_floor <= i_cur_floor;
            if (w_req_bad)
                r_req_err <= 1'b1;
        end
    end

    assign o_car_state     = r_state;
    assign o_door_open     = (r_state == S_DOOR_OPEN);
    assign o_pending_stops = r_pending;
    assign o_served_valid  = r_served_valid;
    assign o_served_floor  = r_served_floor;
    assign o_req_err       = r_req_err;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl: hand-computed trips, door dwell/hold,
// request errors, direction preference and reset behaviour.
module tb_elevator_car_ctrl;

    localparam int NF = 7;
    localparam logic [31:0] ST_IDLE = 0;
    localparam logic [31:0] ST_UP   = 1;
    localparam logic [31:0] ST_DN   = 2;
    localparam logic [31:0] ST_DOOR = 3;

    logic          clk;
    logic          rst_n;
    logic          reqValid;
    logic [2:0]    reqFloor;
    logic [NF-1:0] carCall;
    logic [2:0]    curFloor;
    logic          inPosition;
    logic          doorHold;
    logic [1:0]    carState;
    logic          doorOpen;
    logic [NF-1:0] pendingStops;
    logic          servedValid;
    logic [2:0]    servedFloor;
    logic          reqErr;

    int testCount = 0;
    int failCount = 0;

    elevator_car_ctrl #(.NUM_FLOORS(NF), .DOOR_OPEN_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (reqValid),
        .i_req_floor    (reqFloor),
        .i_car_call     (carCall),
        .i_cur_floor    (curFloor),
        .i_in_position  (inPosition),
        .i_door_hold    (doorHold),
        .o_car_state    (carState),
        .o_door_open    (doorOpen),
        .o_pending_stops(pendingStops),
        .o_served_valid (servedValid),
        .o_served_floor (servedFloor),
        .o_req_err      (reqErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just past the capturing edge.
    task automatic applyStimulus(input logic v, input logic [2:0] f, input logic [NF-1:0] cc,
                                 input logic [2:0] cur, input logic pos, input logic hold);
        reqValid   = v;
        reqFloor   = f;
        carCall    = cc;
        curFloor   = cur;
        inPosition = pos;
        doorHold   = hold;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        reqValid = 1'b0; reqFloor = 3'd0; carCall = '0;
        curFloor = 3'd0; inPosition = 1'b1; doorHold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", 32'(carState), ST_IDLE);
        checkOutput("rst_pending", 32'(pendingStops), 32'h0);
        checkOutput("rst_door", 32'(doorOpen), 32'h0);
        checkOutput("rst_err", 32'(reqErr), 32'h0);
        checkOutput("rst_served", 32'(servedValid), 32'h0);
        rst_n = 1'b1;

        // Trip 0 -> 5, passing 1..4
        applyStimulus(1, 3'd5, '0, 3'd0, 1, 0);
        checkOutput("t2_pending", 32'(pendingStops), 32'h20);
        checkOutput("t2_idle", 32'(carState), ST_IDLE);
        applyStimulus(0, 3'd0, '0, 3'd0, 1, 0);
        checkOutput("t2_up", 32'(carState), ST_UP);
        applyStimulus(0, 3'd0, '0, 3'd0, 0, 0);
        for (int f = 1; f <= 4; f++) begin
            applyStimulus(0, 3'd0, '0, 3'(f), 1, 0);
            checkOutput("t2_pass", 32'(carState), ST_UP);
        end
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t2_door", 32'(carState), ST_DOOR);
        checkOutput("t2_dooropen", 32'(doorOpen), 32'h1);
        checkOutput("t2_sv", 32'(servedValid), 32'h1);
        checkOutput("t2_sf", 32'(servedFloor), 32'h5);
        checkOutput("t2_clr", 32'(pendingStops), 32'h0);
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t2_svpulse", 32'(servedValid), 32'h0);
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t2_dwell3", 32'(carState), ST_DOOR);
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t2_idle_end", 32'(carState), ST_IDLE);
        checkOutput("t2_dooroff", 32'(doorOpen), 32'h0);

        // Trip 5 -> 3 with door hold and a repeat request
        applyStimulus(0, 3'd0, 7'b0001000, 3'd5, 1, 0);
        checkOutput("t4_pending", 32'(pendingStops), 32'h08);
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t4_down", 32'(carState), ST_DN);
        applyStimulus(0, 3'd0, '0, 3'd5, 0, 0);
        applyStimulus(0, 3'd0, '0, 3'd4, 1, 0);
        checkOutput("t4_pass4", 32'(carState), ST_DN);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t4_door", 32'(carState), ST_DOOR);
        checkOutput("t4_sf", 32'(servedFloor), 32'h3);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        repeat (3) applyStimulus(0, 3'd0, '0, 3'd3, 1, 1);
        checkOutput("t4_held", 32'(carState), ST_DOOR);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        applyStimulus(1, 3'd3, '0, 3'd3, 1, 0);
        checkOutput("t4_repeat_nostore", 32'(pendingStops), 32'h0);
        checkOutput("t4_repeat_open", 32'(carState), ST_DOOR);
        repeat (3) applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t4_restart_dwell", 32'(carState), ST_DOOR);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t4_idle", 32'(carState), ST_IDLE);

        // Out-of-range request
        applyStimulus(1, 3'd7, '0, 3'd3, 1, 0);
        checkOutput("t5_err", 32'(reqErr), 32'h1);
        checkOutput("t5_pending", 32'(pendingStops), 32'h0);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t5_sticky", 32'(reqErr), 32'h1);
        checkOutput("t5_idle", 32'(carState), ST_IDLE);

        // Floor 3, dir down, calls at 1 and 5 -> down first
        applyStimulus(0, 3'd0, 7'b0100010, 3'd3, 1, 0);
        checkOutput("t6_pending", 32'(pendingStops), 32'h22);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t6_down_first", 32'(carState), ST_DN);
        applyStimulus(0, 3'd0, '0, 3'd3, 0, 0);
        applyStimulus(0, 3'd0, '0, 3'd2, 1, 0);
        applyStimulus(0, 3'd0, '0, 3'd1, 1, 0);
        checkOutput("t6_door1", 32'(carState), ST_DOOR);
        checkOutput("t6_pend_left", 32'(pendingStops), 32'h20);
        applyStimulus(0, 3'd0, '0, 3'd1, 1, 0);

        // Asynchronous reset mid-door
        rst_n = 1'b0;
        #1;
        checkOutput("t1_async_state", 32'(carState), ST_IDLE);
        checkOutput("t1_async_pending", 32'(pendingStops), 32'h0);
        checkOutput("t1_async_door", 32'(doorOpen), 32'h0);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t1_err_cleared", 32'(reqErr), 32'h0);
        checkOutput("t1_held_state", 32'(carState), ST_IDLE);
        rst_n = 1'b1;

        // Floor 3, dir up after reset, calls at 1 and 5 -> up first
        applyStimulus(0, 3'd0, 7'b0100010, 3'd3, 1, 0);
        applyStimulus(0, 3'd0, '0, 3'd3, 1, 0);
        checkOutput("t6_up_first", 32'(carState), ST_UP);

        // Collective: add 6 while going up, serve 5, 6, reverse, serve 1
        applyStimulus(0, 3'd0, 7'b1000000, 3'd3, 0, 0);
        checkOutput("t3_pending", 32'(pendingStops), 32'h62);
        applyStimulus(0, 3'd0, '0, 3'd4, 1, 0);
        applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t3_door5", 32'(servedFloor), 32'h5);
        checkOutput("t3_pend5", 32'(pendingStops), 32'h42);
        repeat (4) applyStimulus(0, 3'd0, '0, 3'd5, 1, 0);
        checkOutput("t3_cont_up", 32'(carState), ST_UP);
        applyStimulus(0, 3'd0, '0, 3'd6, 1, 0);
        checkOutput("t3_door6", 32'(carState), ST_DOOR);
        checkOutput("t3_sf6", 32'(servedFloor), 32'h6);
        repeat (4) applyStimulus(0, 3'd0, '0, 3'd6, 1, 0);
        checkOutput("t3_reverse", 32'(carState), ST_DN);
        for (int f = 5; f >= 2; f--) begin
            applyStimulus(0, 3'd0, '0, 3'(f), 1, 0);
            checkOutput("t3_pass_down", 32'(carState), ST_DN);
        end
        applyStimulus(0, 3'd0, '0, 3'd1, 1, 0);
        checkOutput("t3_door1", 32'(carState), ST_DOOR);
        checkOutput("t3_sf1", 32'(servedFloor), 32'h1);
        checkOutput("t3_empty", 32'(pendingStops), 32'h0);
        repeat (4) applyStimulus(0, 3'd0, '0, 3'd1, 1, 0);
        checkOutput("t3_idle", 32'(carState), ST_IDLE);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Per-car motion and door sequencer. One instance per elevator, downstream of the call handler.
- Accumulates stop requests from the call handler's (rf_valid, location) pair and from cabin buttons into a pending-stop mask.
- Runs a collective (SCAN) policy and drives the car state (IDLE / MOVE_UP / MOVE_DOWN / DOOR_OPEN) that the call handler consumes as E1_state/E2_state.

Parameters:
- NUM_FLOORS, 7, floors 0..NUM_FLOORS-1; floor fields are 3 bits.
- DOOR_OPEN_CYCLES, 4, clock cycles the door stays open with no obstruction (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  hall-call assignment strobe (from Ex_rf_valid).
- req_floor  in  3  assigned floor (from Ex_location), sampled when req_valid=1.
- car_call  in  NUM_FLOORS  cabin buttons, level; each set bit is a stop request.
- cur_floor  in  3  floor sensor; valid only when in_position=1.
- in_position  in  1  car is aligned at cur_floor.
- door_hold  in  1  obstruction / door-open button.
- car_state  out  2  0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 DOOR_OPEN (mapped onto E_states at the top level).
- door_open  out  1  1 exactly when car_state==DOOR_OPEN.
- pending_stops  out  NUM_FLOORS  registered pending-stop mask.
- served_valid  out  1  one-cycle pulse when a stop is served.
- served_floor  out  3  floor served; valid with served_valid.
- req_err  out  1  sticky; set by any req_floor >= NUM_FLOORS.

Behaviour:
- Reset (async assert, sync deassert into logic):
  - car_state=IDLE, dir_up=1, pending_stops=0, door counter=0.
  - served_valid=0, served_floor=0, req_err=0, door_open=0.
  - Reset mid-move or mid-door discards all pending stops.
- Request capture:
  - pending_next = pending | onehot(req_floor when req_valid, in range) | car_call.
  - A request is visible on pending_stops the cycle after the capturing edge.
  - Out-of-range req_floor is dropped and sets req_err. req_err clears only on reset.
- Clear rule:
  - The bit for cur_floor clears on the edge that enters DOOR_OPEN.
  - A set and a clear of the same bit on the same edge: the clear wins.
  - That same floor's request arriving while in DOOR_OPEN at that floor is not stored; instead the door counter restarts.
- Definitions: above = |pending[NUM_FLOORS-1:cur_floor+1]; below = |pending[cur_floor-1:0]; here = pending[cur_floor] && in_position.
- IDLE:
  - here -> DOOR_OPEN.
  - else above && (dir_up || !below) -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else stay.
  - The decision is made on the first edge after pending_stops becomes non-zero.
- MOVE_UP / MOVE_DOWN:
  - here -> DOOR_OPEN.
  - Intermediate floors with no pending bit are passed without stopping.
- Boundary guard:
  - MOVE_UP at floor NUM_FLOORS-1, or MOVE_DOWN at floor 0, with in_position=1 and !here -> IDLE (defensive; must never wedge).
- DOOR_OPEN:
  - Entry pulses served_valid and sets served_floor=cur_floor.
  - Counter loads DOOR_OPEN_CYCLES-1 and decrements each cycle.
  - door_hold=1 reloads the counter.
  - At counter==0 with door_hold=0, the next state is:
    - dir_up && above -> MOVE_UP.
    - !dir_up && below -> MOVE_DOWN.
    - Otherwise reverse: above -> MOVE_UP, dir_up=1; below -> MOVE_DOWN, dir_up=0.
    - Neither -> IDLE.
  - Door dwell is exactly DOOR_OPEN_CYCLES cycles absent door_hold.
- car_state never changes while in_position=0, except that DOOR_OPEN is never entered when in_position=0.

Test Plan:
- Reset mid-DOOR_OPEN with pending=7'b0100010 -> next posedge: car_state=IDLE, pending_stops=0, door_open=0, req_err=0.
- Car at floor 0 idle, req_valid with req_floor=5 -> pending=0100000 next cycle, then MOVE_UP. Floors 1-4 are passed. At cur_floor=5: DOOR_OPEN, served_floor=5 pulse, dwell 4 cycles, then IDLE.
- Moving up at floor 2 with pending {4,1}; car_call[6] set -> stops at 4 then 6 (continues up), then reverses to MOVE_DOWN and serves 1.
- At floor 3 in DOOR_OPEN, door_hold held for 3 cycles mid-dwell -> door stays open 3+4 cycles total after release; a repeat req_floor=3 restarts the counter and is not stored.
- req_floor=7 with NUM_FLOORS=7 -> pending unchanged, req_err=1 and stays 1 until reset.
- IDLE at floor 3 with simultaneous requests for 1 and 5, dir_up=1 -> MOVE_UP first; same case with dir_up=0 -> MOVE_DOWN first.
